// File: rtl/acoustics_pkg.sv
// Shared types and constants for the acoustic ADC capture path.
// Holds the capture FSM encoding and the saturating magnitude helper.
package acoustics_pkg;

    localparam int SAMPLE_W = 16;
    localparam int NCHAN    = 4;
    localparam int WORD_W   = SAMPLE_W * NCHAN;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } cap_state_t;

    // |x| with the most negative code saturated, so the result fits the positive range.
    function automatic logic [SAMPLE_W-1:0] sample_mag(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] most_neg;
        logic [SAMPLE_W-1:0] result;
        most_neg = {1'b1, {(SAMPLE_W-1){1'b0}}};
        if (x == most_neg) begin
            result = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (x[SAMPLE_W-1]) begin
            result = (~x) + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        end else begin
            result = x;
        end
        return result;
    endfunction

endpackage

// File: rtl/ping_ram.sv
// Simple dual-port sample RAM: one 64-bit write port, one lane-selected read port.
// Address and lane are registered together; the selected lane is registered again on output.
module ping_ram
    import acoustics_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [WORD_W-1:0]   wdata,
    input  logic [AW-1:0]       raddr,
    input  logic [1:0]          rlane,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       raddr_q;
    logic [1:0]          lane_q;
    logic [WORD_W-1:0]   word;
    logic [SAMPLE_W-1:0] lane_data;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign word = mem[raddr_q];

    always_comb begin
        lane_data = word[SAMPLE_W-1:0];
        case (lane_q)
            2'd0:    lane_data = word[1*SAMPLE_W-1:0*SAMPLE_W];
            2'd1:    lane_data = word[2*SAMPLE_W-1:1*SAMPLE_W];
            2'd2:    lane_data = word[3*SAMPLE_W-1:2*SAMPLE_W];
            default: lane_data = word[4*SAMPLE_W-1:3*SAMPLE_W];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q <= '0;
            lane_q  <= '0;
            rdata   <= '0;
        end else begin
            raddr_q <= raddr;
            lane_q  <= rlane;
            rdata   <= lane_data;
        end
    end

endmodule

// File: rtl/ping_capture.sv
// Four-channel triggered capture buffer: records into a circular RAM once armed,
// freezes a pre/post window around the first channel-A threshold crossing.
module ping_capture
    import acoustics_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int PRE   = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                wrclk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] chanA,
    input  logic [SAMPLE_W-1:0] chanB,
    input  logic [SAMPLE_W-1:0] chanC,
    input  logic [SAMPLE_W-1:0] chanD,
    input  logic                chanAvalid,
    input  logic                chanBvalid,
    input  logic                chanCvalid,
    input  logic                chanDvalid,
    input  logic                arm,
    input  logic [SAMPLE_W-1:0] threshold,
    input  logic [1:0]          rd_chan,
    input  logic [AW-1:0]       rd_idx,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                data_rdy,
    output logic                busy,
    output logic                skew_err,
    output logic [2:0]          state_dbg,
    output logic [AW-1:0]       wr_ptr_dbg
);

    localparam logic [AW-1:0] PRE_OFS       = AW'(PRE);
    localparam logic [AW-1:0] FILL_LAST_CNT = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LAST_CNT = AW'(DEPTH - PRE - 1);

    cap_state_t state;
    cap_state_t state_next;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] cnt;
    logic [AW-1:0] trig_ptr;
    logic [AW-1:0] win_start;
    logic [AW-1:0] rd_addr;

    logic [3:0]          valids;
    logic                accepted;
    logic                partial;
    logic [SAMPLE_W-1:0] mag_a;
    logic                over_thr;

    // Output-comb controls
    logic we;
    logic fill_step;
    logic trig_hit;
    logic post_step;
    logic post_last;

    assign valids   = {chanDvalid, chanCvalid, chanBvalid, chanAvalid};
    assign accepted = &valids;
    assign partial  = (|valids) && !accepted;
    assign mag_a    = sample_mag(chanA);
    assign over_thr = mag_a > threshold;

    // State register
    always_ff @(posedge wrclk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; arm restarts from any state
    always_comb begin
        state_next = state;
        if (arm) begin
            state_next = FILL;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                FILL: if (accepted && cnt == FILL_LAST_CNT) state_next = WAIT;
                WAIT: if (accepted && over_thr) state_next = POST;
                POST: if (accepted && cnt == POST_LAST_CNT) state_next = DONE;
                DONE: state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: per-cycle datapath controls decoded from state and inputs
    always_comb begin
        we        = 1'b0;
        fill_step = 1'b0;
        trig_hit  = 1'b0;
        post_step = 1'b0;
        post_last = 1'b0;
        if (!arm && accepted) begin
            case (state)
                FILL: begin
                    we        = 1'b1;
                    fill_step = 1'b1;
                end
                WAIT: begin
                    we       = 1'b1;
                    trig_hit = over_thr;
                end
                POST: begin
                    we        = 1'b1;
                    post_step = 1'b1;
                    post_last = (cnt == POST_LAST_CNT);
                end
                default: begin
                    we = 1'b0;
                end
            endcase
        end
    end

    // Pointers, counters and registered status
    always_ff @(posedge wrclk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            cnt      <= '0;
            trig_ptr <= '0;
            data_rdy <= 1'b0;
            busy     <= 1'b0;
            skew_err <= 1'b0;
        end else begin
            busy     <= (state_next == FILL) || (state_next == WAIT) || (state_next == POST);
            data_rdy <= (state_next == DONE);
            if (arm) begin
                wr_ptr   <= '0;
                cnt      <= '0;
                skew_err <= 1'b0;
            end else begin
                if (partial) begin
                    skew_err <= 1'b1;
                end
                if (we) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (trig_hit) begin
                    trig_ptr <= wr_ptr;
                    cnt      <= {{(AW-1){1'b0}}, 1'b1};
                end else if (fill_step || post_step) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Logical index 0 is PRE samples before the trigger, with natural AW-bit wrap.
    assign win_start = trig_ptr - PRE_OFS;
    assign rd_addr   = win_start + rd_idx;

    ping_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (wrclk),
        .rst_n (rst),
        .we    (we),
        .waddr (wr_ptr),
        .wdata ({chanD, chanC, chanB, chanA}),
        .raddr (rd_addr),
        .rlane (rd_chan),
        .rdata (rd_data)
    );

    assign state_dbg  = state;
    assign wr_ptr_dbg = wr_ptr;

    logic unused_ok;
    assign unused_ok = post_last;

endmodule
